// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits (LSB- or MSB-first), stop bit,
// delivered through a single-entry valid/ready output register.
module serial_frame_receiver #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_in,
  input  logic             bit_en,
  input  logic             msb_first,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    STOP
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [WIDTH-1:0] sh;
  logic            mode;
  logic            last_bit;
  logic            start_bit;
  logic            good_frame;
  logic            bad_frame;

  assign last_bit   = (cnt == CW'(WIDTH - 1));
  assign start_bit  = bit_en && (state == IDLE) && !serial_in;
  assign good_frame = bit_en && (state == STOP) && serial_in;
  assign bad_frame  = bit_en && (state == STOP) && !serial_in;
  assign busy       = (state == DATA) || (state == STOP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (bit_en) begin
      case (state)
        IDLE: if (!serial_in) state_next = DATA;
        DATA: if (last_bit) state_next = STOP;
        STOP: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Shift mode is latched at the start bit so msb_first may change mid-frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      sh   <= '0;
      mode <= 1'b0;
    end else if (start_bit) begin
      cnt  <= '0;
      mode <= msb_first;
    end else if (bit_en && (state == DATA)) begin
      cnt <= cnt + 1'b1;
      if (mode) begin
        sh <= {sh[WIDTH-2:0], serial_in};
      end else begin
        sh <= {serial_in, sh[WIDTH-1:1]};
      end
    end
  end

  // A completing frame may reuse the slot only if it is empty or being consumed now.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= bad_frame;
      overrun   <= good_frame && data_valid && !data_ready;
      if (good_frame && (!data_valid || data_ready)) begin
        data_out   <= sh;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed self-checking bench for serial_frame_receiver (WIDTH=8).
module tb_serial_frame_receiver;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic       bit_en;
  logic       msb_first;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int checks;
  int failures;

  serial_frame_receiver #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .serial_in (serial_in),
    .bit_en    (bit_en),
    .msb_first (msb_first),
    .data_out  (data_out),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one bit_en strobe, returns at a later negedge.
  task automatic applyStimulus(input logic b, input int gap);
    serial_in = b;
    bit_en    = 1'b1;
    @(negedge clk);
    bit_en    = 1'b0;
    serial_in = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendFrame(input logic [7:0] v, input logic msbf, input logic stopb,
                           input logic rdy, input int gap);
    msb_first = msbf;
    applyStimulus(1'b0, gap);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(msbf ? v[7-i] : v[i], gap);
    end
    serial_in  = stopb;
    bit_en     = 1'b1;
    data_ready = rdy;
    @(negedge clk);
    bit_en     = 1'b0;
    serial_in  = 1'b1;
    data_ready = 1'b0;
  endtask

  task automatic consume;
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b1;
    serial_in  = 1'b1;
    bit_en     = 1'b0;
    msb_first  = 1'b0;
    data_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_data_out", 16'(data_out), 16'h0000);
    checkOutput("rst_valid", 16'(data_valid), 16'h0);
    checkOutput("rst_busy", 16'(busy), 16'h0);
    checkOutput("rst_frame_err", 16'(frame_err), 16'h0);
    checkOutput("rst_overrun", 16'(overrun), 16'h0);
    rst = 1'b0;
    @(negedge clk);

    // LSB-first, line bits 1,0,1,0,0,1,0,1
    sendFrame(8'hA5, 1'b0, 1'b1, 1'b0, 2);
    checkOutput("lsb_valid", 16'(data_valid), 16'h1);
    checkOutput("lsb_data", 16'(data_out), 16'h00A5);
    checkOutput("lsb_busy_after", 16'(busy), 16'h0);
    consume();
    checkOutput("consume_valid", 16'(data_valid), 16'h0);
    checkOutput("consume_data_held", 16'(data_out), 16'h00A5);
    consume();
    checkOutput("ready_no_valid", 16'(data_valid), 16'h0);

    // MSB-first 1,1,0,0,0,0,0,1 with msb_first toggled mid-frame
    msb_first = 1'b1;
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    msb_first = 1'b0;
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 1);
    applyStimulus(1'b1, 1);
    checkOutput("msb_busy_stop", 16'(busy), 16'h1);
    applyStimulus(1'b1, 0);
    checkOutput("msb_valid", 16'(data_valid), 16'h1);
    checkOutput("msb_data", 16'(data_out), 16'h00C1);
    consume();

    // Bad stop bit, then a good frame
    sendFrame(8'hFF, 1'b0, 1'b0, 1'b0, 1);
    checkOutput("ferr_pulse", 16'(frame_err), 16'h1);
    checkOutput("ferr_no_overrun", 16'(overrun), 16'h0);
    checkOutput("ferr_valid", 16'(data_valid), 16'h0);
    checkOutput("ferr_data_held", 16'(data_out), 16'h00C1);
    @(negedge clk);
    checkOutput("ferr_one_cycle", 16'(frame_err), 16'h0);
    sendFrame(8'h3C, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("after_ferr_valid", 16'(data_valid), 16'h1);
    checkOutput("after_ferr_data", 16'(data_out), 16'h003C);
    consume();

    // Overrun: second frame dropped while first is unconsumed
    sendFrame(8'h11, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("ovr_first_data", 16'(data_out), 16'h0011);
    sendFrame(8'h22, 1'b0, 1'b1, 1'b0, 0);
    checkOutput("ovr_pulse", 16'(overrun), 16'h1);
    checkOutput("ovr_no_ferr", 16'(frame_err), 16'h0);
    checkOutput("ovr_data_kept", 16'(data_out), 16'h0011);
    checkOutput("ovr_valid", 16'(data_valid), 16'h1);
    @(negedge clk);
    checkOutput("ovr_one_cycle", 16'(overrun), 16'h0);
    sendFrame(8'h22, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("replace_no_ovr", 16'(overrun), 16'h0);
    checkOutput("replace_data", 16'(data_out), 16'h0022);
    checkOutput("replace_valid", 16'(data_valid), 16'h1);
    consume();

    // Reset after 4 data bits
    msb_first = 1'b0;
    applyStimulus(1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0);
    checkOutput("mid_frame_busy", 16'(busy), 16'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy", 16'(busy), 16'h0);
    checkOutput("midrst_data", 16'(data_out), 16'h0000);
    checkOutput("midrst_valid", 16'(data_valid), 16'h0);
    checkOutput("midrst_flags", 16'({frame_err, overrun}), 16'h0);
    sendFrame(8'h5A, 1'b0, 1'b1, 1'b0, 1);
    checkOutput("post_rst_data", 16'(data_out), 16'h005A);
    consume();

    // Same bits at bit_en every 3rd clk and every clk, then back-to-back
    sendFrame(8'h96, 1'b1, 1'b1, 1'b0, 2);
    checkOutput("slow_data", 16'(data_out), 16'h0096);
    consume();
    sendFrame(8'h96, 1'b1, 1'b1, 1'b0, 0);
    checkOutput("fast_data", 16'(data_out), 16'h0096);
    sendFrame(8'h4B, 1'b0, 1'b1, 1'b1, 0);
    checkOutput("b2b_data", 16'(data_out), 16'h004B);
    checkOutput("b2b_no_ovr", 16'(overrun), 16'h0);
    consume();
    checkOutput("final_valid", 16'(data_valid), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
